// File: rtl/tile_switch_sequencer.sv
// Active-tile selector for the micro-tile container: debounces the requested tile and
// walks every change through quiesce, clock-off and start-under-reset phases.
module tile_switch_sequencer #(
    parameter int NUM_TILES     = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int RST_CYCLES    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           sel_req,
    input  logic                 ext_rst_n,
    output logic [NUM_TILES-1:0] tile_clk_en,
    output logic [NUM_TILES-1:0] tile_rst_n,
    output logic [1:0]           out_sel,
    output logic                 out_blank,
    output logic                 busy,
    output logic [7:0]           switch_cnt
);

    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);
    localparam logic [7:0] CNT_LAST = 8'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_QUIESCE,
        ST_OFF,
        ST_START
    } state_t;

    state_t               r_state;
    logic [1:0]           r_syncA;
    logic [1:0]           r_syncB;
    logic [1:0]           r_cand;
    logic [3:0]           r_stabCnt;
    logic [1:0]           r_active;
    logic [1:0]           r_target;
    logic [7:0]           r_cnt;
    logic                 r_fromIdle;
    logic [NUM_TILES-1:0] r_clkEn;
    logic [1:0]           r_outSel;
    logic                 r_outBlank;
    logic                 r_busy;
    logic [7:0]           r_switchCnt;
    logic                 w_stable;

    function automatic logic [NUM_TILES-1:0] f_onehot(input logic [1:0] idx);
        logic [NUM_TILES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign w_stable = (r_stabCnt == STAB_MAX);

    // Two-flop synchronizer followed by a saturating run-length counter on the candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_syncA   <= '0;
            r_syncB   <= '0;
            r_cand    <= '0;
            r_stabCnt <= '0;
        end else begin
            r_syncA <= sel_req;
            r_syncB <= r_syncA;
            if (r_syncB != r_cand) begin
                r_cand    <= r_syncB;
                r_stabCnt <= '0;
            end else if (r_stabCnt < STAB_MAX) begin
                r_stabCnt <= r_stabCnt + 4'd1;
            end
        end
    end

    // Outputs are loaded on the transition into each phase so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_active    <= '0;
            r_target    <= '0;
            r_cnt       <= '0;
            r_fromIdle  <= 1'b0;
            r_clkEn     <= '0;
            r_outSel    <= '0;
            r_outBlank  <= 1'b1;
            r_busy      <= 1'b1;
            r_switchCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_stable) begin
                        r_target   <= r_cand;
                        r_cnt      <= '0;
                        r_fromIdle <= 1'b1;
                        r_clkEn    <= f_onehot(r_cand);
                        r_outSel   <= r_cand;
                        r_state    <= ST_START;
                    end
                end
                ST_RUN: begin
                    if (w_stable && (r_cand != r_active)) begin
                        r_target   <= r_cand;
                        r_cnt      <= '0;
                        r_outBlank <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_QUIESCE;
                    end
                end
                ST_QUIESCE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_clkEn <= '0;
                        r_state <= ST_OFF;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_OFF: begin
                    r_active   <= r_target;
                    r_cnt      <= '0;
                    r_fromIdle <= 1'b0;
                    r_clkEn    <= f_onehot(r_target);
                    r_outSel   <= r_target;
                    r_state    <= ST_START;
                end
                ST_START: begin
                    if (r_cnt == CNT_LAST) begin
                        r_active   <= r_target;
                        r_outBlank <= 1'b0;
                        r_busy     <= 1'b0;
                        if (!r_fromIdle) begin
                            r_switchCnt <= r_switchCnt + 8'd1;
                        end
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Only the running tile sees the board reset; every other phase holds all tiles in reset.
    assign tile_rst_n  = r_busy ? '0 : (f_onehot(r_active) & {NUM_TILES{ext_rst_n}});
    assign tile_clk_en = r_clkEn;
    assign out_sel     = r_outSel;
    assign out_blank   = r_outBlank;
    assign busy        = r_busy;
    assign switch_cnt  = r_switchCnt;

endmodule

// File: tb/tb_tile_switch_sequencer.sv
// Self-checking bench for tile_switch_sequencer: directed vector table, hand-written
// corner sequences and a randomized run against a phase-plan reference model.
module tb_tile_switch_sequencer;

    localparam int STABLE = 4;
    localparam int RSTC   = 8;
    localparam int NV     = 13;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [1:0] sel_req   = 2'd2;
    logic       ext_rst_n = 1'b1;
    logic [3:0] tile_clk_en;
    logic [3:0] tile_rst_n;
    logic [1:0] out_sel;
    logic       out_blank;
    logic       busy;
    logic [7:0] switch_cnt;

    int nChecks = 0;
    int nFail   = 0;

    tile_switch_sequencer #(
        .NUM_TILES(4),
        .STABLE_CYCLES(STABLE),
        .RST_CYCLES(RSTC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sel_req(sel_req),
        .ext_rst_n(ext_rst_n),
        .tile_clk_en(tile_clk_en),
        .tile_rst_n(tile_rst_n),
        .out_sel(out_sel),
        .out_blank(out_blank),
        .busy(busy),
        .switch_cnt(switch_cnt)
    );

    always #5 clk = ~clk;

    // One expected output frame per clock cycle; a switch is pre-planned as a list of frames.
    typedef struct {
        logic [3:0] clkEn;
        logic       isRun;
        logic       isIdle;
        logic [1:0] tile;
        logic       selCare;
        logic [1:0] outSel;
        logic [7:0] swcnt;
    } frame_t;

    typedef struct {
        logic       rstV;
        logic [1:0] sel;
        logic       ext;
        int         n;
        logic [3:0] expClk;
        logic [3:0] expRstN;
        logic [1:0] expSel;
        logic       selCare;
        logic       expBlank;
        logic       expBusy;
        logic [7:0] expCnt;
    } vec_t;

    frame_t     mCur;
    frame_t     mPlan[$];
    logic [1:0] mSyncA;
    logic [1:0] mSyncB;
    logic [1:0] mCand;
    int         mStab;
    vec_t       vecs[NV];

    function automatic logic [3:0] oneHot(input logic [1:0] t);
        logic [3:0] base;
        base = 4'b0001;
        return base << t;
    endfunction

    function automatic frame_t mkFrame(input logic [3:0] clkEn, input logic isRun,
                                       input logic isIdle, input logic [1:0] tile,
                                       input logic selCare, input logic [1:0] outSel,
                                       input logic [7:0] swcnt);
        frame_t f;
        f.clkEn   = clkEn;
        f.isRun   = isRun;
        f.isIdle  = isIdle;
        f.tile    = tile;
        f.selCare = selCare;
        f.outSel  = outSel;
        f.swcnt   = swcnt;
        return f;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCur = mkFrame(4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 8'd0);
        mPlan.delete();
        mSyncA = '0;
        mSyncB = '0;
        mCand  = '0;
        mStab  = 0;
    endtask

    // Advances the reference by one clock edge using the inputs held before the edge.
    task automatic modelEdge();
        logic       stable;
        logic [1:0] t;
        logic [1:0] old;
        logic [7:0] sw;
        if (rst) begin
            modelReset();
            return;
        end
        stable = (mStab == STABLE);
        t      = mCand;
        old    = mCur.tile;
        sw     = mCur.swcnt;
        if (mPlan.size() == 0) begin
            if (mCur.isIdle && stable) begin
                for (int i = 0; i < RSTC; i++)
                    mPlan.push_back(mkFrame(oneHot(t), 1'b0, 1'b0, t, 1'b1, t, sw));
                mPlan.push_back(mkFrame(oneHot(t), 1'b1, 1'b0, t, 1'b1, t, sw));
            end else if (mCur.isRun && stable && (t != old)) begin
                for (int i = 0; i < RSTC; i++)
                    mPlan.push_back(mkFrame(oneHot(old), 1'b0, 1'b0, old, 1'b0, old, sw));
                mPlan.push_back(mkFrame(4'b0000, 1'b0, 1'b0, old, 1'b0, old, sw));
                for (int i = 0; i < RSTC; i++)
                    mPlan.push_back(mkFrame(oneHot(t), 1'b0, 1'b0, t, 1'b1, t, sw));
                mPlan.push_back(mkFrame(oneHot(t), 1'b1, 1'b0, t, 1'b1, t, sw + 8'd1));
            end
        end
        if (mPlan.size() > 0) mCur = mPlan.pop_front();
        if (mSyncB != mCand) begin
            mCand = mSyncB;
            mStab = 0;
        end else if (mStab < STABLE) begin
            mStab++;
        end
        mSyncB = mSyncA;
        mSyncA = sel_req;
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] s, input logic e);
        #1;
        rst       = r;
        sel_req   = s;
        ext_rst_n = e;
        if (r) modelReset();
        @(negedge clk);
    endtask

    task automatic checkOutput();
        logic [3:0] expRstN;
        expRstN = (mCur.isRun && ext_rst_n) ? oneHot(mCur.tile) : 4'b0000;
        cmp("tile_clk_en", 8'(tile_clk_en), 8'(mCur.clkEn));
        cmp("tile_rst_n", 8'(tile_rst_n), 8'(expRstN));
        if (mCur.selCare) cmp("out_sel", 8'(out_sel), 8'(mCur.outSel));
        cmp("out_blank", 8'(out_blank), 8'(!mCur.isRun));
        cmp("busy", 8'(busy), 8'(!mCur.isRun));
        cmp("switch_cnt", switch_cnt, mCur.swcnt);
        cmp("clk_en_onehot", 8'($countones(tile_clk_en) <= 1), 8'd1);
    endtask

    task automatic checkVec(input vec_t v);
        cmp("vec.tile_clk_en", 8'(tile_clk_en), 8'(v.expClk));
        cmp("vec.tile_rst_n", 8'(tile_rst_n), 8'(v.expRstN));
        if (v.selCare) cmp("vec.out_sel", 8'(out_sel), 8'(v.expSel));
        cmp("vec.out_blank", 8'(out_blank), 8'(v.expBlank));
        cmp("vec.busy", 8'(busy), 8'(v.expBusy));
        cmp("vec.switch_cnt", switch_cnt, v.expCnt);
    endtask

    task automatic finishCycle();
        @(posedge clk);
        modelEdge();
    endtask

    task automatic runCycle(input logic r, input logic [1:0] s, input logic e);
        applyStimulus(r, s, e);
        checkOutput();
        finishCycle();
    endtask

    initial begin
        int         run3;
        logic       rRst;
        logic [1:0] rSel;
        logic       rExt;

        // Power-up to tile 2, switch 2->1, short glitch, board reset on tile 1.
        vecs[0]  = '{1'b1, 2'd2, 1'b1, 3,  4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b1, 8'd0};
        vecs[1]  = '{1'b0, 2'd2, 1'b1, 8,  4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b1, 8'd0};
        vecs[2]  = '{1'b0, 2'd2, 1'b1, 8,  4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b1, 8'd0};
        vecs[3]  = '{1'b0, 2'd2, 1'b1, 4,  4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 2'd1, 1'b1, 8,  4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 8,  4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1, 8'd0};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 1,  4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1, 8'd0};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 8,  4'b0010, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b1, 8'd0};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 4,  4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, 2'd3, 1'b1, 2,  4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 2'd1, 1'b1, 10, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 5,  4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[12] = '{1'b0, 2'd1, 1'b1, 2,  4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1};

        @(posedge clk);
        modelReset();

        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                applyStimulus(vecs[v].rstV, vecs[v].sel, vecs[v].ext);
                checkOutput();
                checkVec(vecs[v]);
                finishCycle();
            end
        end

        // Request 1->3, then change to 0 during the quiesce phase.
        for (int k = 0; k < 8; k++) runCycle(1'b0, 2'd3, 1'b1);
        run3 = 0;
        for (int k = 0; k < 60; k++) begin
            applyStimulus(1'b0, 2'd0, 1'b1);
            checkOutput();
            if (tile_clk_en == 4'b1000 && !busy) run3++;
            finishCycle();
        end
        cmp("run_on_tile3_cycles", 8'(run3), 8'd1);
        cmp("mid_switch_final_cnt", switch_cnt, 8'd3);
        cmp("mid_switch_final_sel", 8'(out_sel), 8'd0);

        // Board reset on tile 0 only reaches that tile and leaves the sequencer running.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 2'd0, 1'b0);
            checkOutput();
            cmp("ext_rst_tile_rst_n", 8'(tile_rst_n), 8'h00);
            cmp("ext_rst_busy", 8'(busy), 8'd0);
            finishCycle();
        end
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkOutput();
        cmp("ext_rst_release", 8'(tile_rst_n), 8'h01);
        finishCycle();

        // Async reset in the fourth cycle of START for a 0->2 switch.
        for (int k = 0; k < 20; k++) runCycle(1'b0, 2'd2, 1'b1);
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        cmp("async_clk_en", 8'(tile_clk_en), 8'h00);
        cmp("async_rst_n", 8'(tile_rst_n), 8'h00);
        cmp("async_blank", 8'(out_blank), 8'd1);
        cmp("async_busy", 8'(busy), 8'd1);
        cmp("async_cnt", switch_cnt, 8'd0);
        cmp("async_sel", 8'(out_sel), 8'd0);
        @(negedge clk);
        checkOutput();
        finishCycle();
        for (int k = 0; k < 2; k++) runCycle(1'b1, 2'd2, 1'b1);
        for (int k = 0; k < 30; k++) runCycle(1'b0, 2'd2, 1'b1);
        cmp("reentry_clk_en", 8'(tile_clk_en), 8'h04);
        cmp("reentry_busy", 8'(busy), 8'd0);
        cmp("reentry_cnt", switch_cnt, 8'd0);

        // Randomized select changes, board resets and rare async resets.
        rSel = 2'd2;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 11) == 0) rSel = 2'($urandom_range(0, 3));
            rExt = ($urandom_range(0, 9) != 0);
            rRst = ($urandom_range(0, 249) == 0);
            runCycle(rRst, rSel, rExt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
